// File: rtl/sensor_frame_writer_if.sv
// Sample word stream between the sensor front end and the frame writer.
// Plain valid/ready handshake; a word moves when s_valid_i & s_ready_o.
interface sensor_frame_writer_if #(
    parameter int WIDTH = 32
);
    logic             s_valid_i;
    logic [WIDTH-1:0] s_data_i;
    logic             s_ready_o;

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o
    );
endinterface

// File: rtl/sensor_frame_writer.sv
// Groups stream words into 4-word frames and commits them to a circular
// store of four sample banks; indexed 1-cycle read port for the MLP.
module sensor_frame_writer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 600,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    sensor_frame_writer_if.slave s,
    output logic             frame_done_o,
    output logic [IDX_W-1:0] wr_ptr_o,
    output logic [IDX_W-1:0] count_o,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic             rd_err_o,
    output logic [WIDTH-1:0] rd_temp_o,
    output logic [WIDTH-1:0] rd_hum_o,
    output logic [WIDTH-1:0] rd_pres_o,
    output logic [WIDTH-1:0] rd_vco_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] FULL = IDX_W'(DEPTH);

    typedef enum logic {
        COLLECT,
        COMMIT
    } state_t;

    state_t           state;
    logic [1:0]       chan;
    logic [WIDTH-1:0] stage [4];

    logic [WIDTH-1:0] bank_t [DEPTH];
    logic [WIDTH-1:0] bank_h [DEPTH];
    logic [WIDTH-1:0] bank_p [DEPTH];
    logic [WIDTH-1:0] bank_v [DEPTH];

    logic accept;
    logic commit;
    logic rd_miss;

    // Clear blocks acceptance in the same cycle so no word is half-taken.
    assign s.s_ready_o = (state == COLLECT) & ~clear_i;
    assign accept      = s.s_valid_i & s.s_ready_o;
    assign commit      = (state == COMMIT) & ~clear_i;
    assign rd_miss     = rd_idx_i >= count_o;

    // Frame sequencing: collect four words, then one commit cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= COLLECT;
            chan         <= 2'd0;
            wr_ptr_o     <= '0;
            count_o      <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (clear_i) begin
                state    <= COLLECT;
                chan     <= 2'd0;
                wr_ptr_o <= '0;
                count_o  <= '0;
            end else begin
                unique case (state)
                    COLLECT: begin
                        if (accept) begin
                            chan <= chan + 2'd1;
                            if (chan == 2'd3) begin
                                state <= COMMIT;
                            end
                        end
                    end
                    COMMIT: begin
                        frame_done_o <= 1'b1;
                        wr_ptr_o     <= (wr_ptr_o == LAST) ? '0
                                                           : wr_ptr_o + 1'b1;
                        if (count_o != FULL) begin
                            count_o <= count_o + 1'b1;
                        end
                        state <= COLLECT;
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

    // Staging holds the partial frame; chan reset makes stale words moot.
    always_ff @(posedge clk) begin
        if (accept) begin
            stage[chan] <= s.s_data_i;
        end
    end

    // Bank write; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (commit) begin
            bank_t[wr_ptr_o[AW-1:0]] <= stage[0];
            bank_h[wr_ptr_o[AW-1:0]] <= stage[1];
            bank_p[wr_ptr_o[AW-1:0]] <= stage[2];
            bank_v[wr_ptr_o[AW-1:0]] <= stage[3];
        end
    end

    // Registered read; sees pre-commit contents on a same-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_o <= 1'b0;
            rd_err_o   <= 1'b0;
            rd_temp_o  <= '0;
            rd_hum_o   <= '0;
            rd_pres_o  <= '0;
            rd_vco_o   <= '0;
        end else begin
            rd_valid_o <= rd_en_i;
            rd_err_o   <= rd_en_i & rd_miss;
            if (rd_en_i) begin
                if (rd_miss) begin
                    rd_temp_o <= '0;
                    rd_hum_o  <= '0;
                    rd_pres_o <= '0;
                    rd_vco_o  <= '0;
                end else begin
                    rd_temp_o <= bank_t[rd_idx_i[AW-1:0]];
                    rd_hum_o  <= bank_h[rd_idx_i[AW-1:0]];
                    rd_pres_o <= bank_p[rd_idx_i[AW-1:0]];
                    rd_vco_o  <= bank_v[rd_idx_i[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_frame_writer.sv
// Scoreboard bench for sensor_frame_writer (DEPTH=4 to reach wrap quickly).
// Stimulus pushes expected reads/commits; a negedge monitor pops and checks.
module tb_sensor_frame_writer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          rd_en = 1'b0;
    logic [IW-1:0] rd_idx = '0;
    logic          frame_done;
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] count;
    logic          rd_valid;
    logic          rd_err;
    logic [W-1:0]  rd_temp, rd_hum, rd_pres, rd_vco;

    sensor_frame_writer_if #(.WIDTH(W)) s_if ();

    sensor_frame_writer #(.WIDTH(W), .DEPTH(D), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .s            (s_if),
        .frame_done_o (frame_done),
        .wr_ptr_o     (wr_ptr),
        .count_o      (count),
        .rd_en_i      (rd_en),
        .rd_idx_i     (rd_idx),
        .rd_valid_o   (rd_valid),
        .rd_err_o     (rd_err),
        .rd_temp_o    (rd_temp),
        .rd_hum_o     (rd_hum),
        .rd_pres_o    (rd_pres),
        .rd_vco_o     (rd_vco)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         err;
        logic [W-1:0] t;
        logic [W-1:0] h;
        logic [W-1:0] p;
        logic [W-1:0] v;
    } rd_exp_t;

    typedef struct packed {
        logic [IW-1:0] ptr;
        logic [IW-1:0] cnt;
    } fd_exp_t;

    rd_exp_t rq[$];
    fd_exp_t fq[$];
    rd_exp_t re;
    fd_exp_t fe;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int stall_cnt = 0;
    logic [IW-1:0] exp_ptr = '0;
    logic [IW-1:0] exp_cnt = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fw(input int tag, input int ch);
        return W'((tag << 8) | ch);
    endfunction

    // Monitor: every rd_valid / frame_done must match a queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got rd_valid=1 expected 0");
                end else begin
                    re = rq.pop_front();
                    chk("rd_err", rd_err, re.err);
                    chk("rd_temp", rd_temp, re.t);
                    chk("rd_hum", rd_hum, re.h);
                    chk("rd_pres", rd_pres, re.p);
                    chk("rd_vco", rd_vco, re.v);
                end
            end
            if (frame_done) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fd_unexpected: got frame_done=1 expected 0");
                end else begin
                    fe = fq.pop_front();
                    chk("fd_wr_ptr", wr_ptr, fe.ptr);
                    chk("fd_count", count, fe.cnt);
                end
            end
        end
    end

    task automatic model_commit();
        exp_ptr = (exp_ptr == IW'(D - 1)) ? '0 : exp_ptr + 1'b1;
        if (exp_cnt < IW'(D)) exp_cnt = exp_cnt + 1'b1;
        fq.push_back('{exp_ptr, exp_cnt});
    endtask

    task automatic send_word(input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = s_if.s_ready_o;
            cyc_cnt++;
            if (!ok) stall_cnt++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic send_frame(input int tag);
        for (int c = 0; c < 4; c++) send_word(fw(tag, c));
        model_commit();
    endtask

    task automatic idle(input int n);
        s_if.s_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input int idx, input logic err,
                      input logic [W-1:0] t, input logic [W-1:0] h,
                      input logic [W-1:0] p, input logic [W-1:0] v);
        rd_en  = 1'b1;
        rd_idx = IW'(idx);
        rq.push_back('{err, t, h, p, v});
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic rdf(input int idx, input int tag);
        rd(idx, 1'b0, fw(tag, 0), fw(tag, 1), fw(tag, 2), fw(tag, 3));
    endtask

    task automatic chk_reset();
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_rd_data", {rd_temp, rd_hum}, 0);
        chk("rst_rd_data2", {rd_pres, rd_vco}, 0);
        chk("rst_s_ready", s_if.s_ready_o, 1);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clk);
        chk("clear_ready_low", s_if.s_ready_o, 0);
        @(posedge clk);
        #1;
        clear   = 1'b0;
        exp_ptr = '0;
        exp_cnt = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        s_if.s_valid_i = 1'b0;
        s_if.s_data_i  = '0;
        #12;
        chk_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", s_if.s_ready_o, 1);

        // 1: first frame, then read it back
        send_word(32'h11);
        send_word(32'h22);
        send_word(32'h33);
        send_word(32'h44);
        model_commit();
        idle(2);
        chk("t1_count", count, 1);
        chk("t1_wr_ptr", wr_ptr, 1);
        rd(0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);

        // 2: valid held across three frames
        cyc_cnt   = 0;
        stall_cnt = 0;
        send_frame(8'hA);
        send_frame(8'hB);
        send_frame(8'hC);
        @(negedge clk);
        cyc_cnt++;
        if (!s_if.s_ready_o) stall_cnt++;
        @(posedge clk);
        #1;
        idle(2);
        chk("t2_cycles", cyc_cnt, 15);
        chk("t2_stalls", stall_cnt, 3);
        chk("t2_count", count, 4);
        chk("t2_wr_ptr", wr_ptr, 0);
        rd(0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        rdf(1, 8'hA);
        rdf(2, 8'hB);
        rdf(3, 8'hC);

        // 3: wrap with six frames
        clear_pulse();
        chk("t3_clr_count", count, 0);
        chk("t3_clr_ptr", wr_ptr, 0);
        for (int f = 1; f <= 6; f++) send_frame(f);
        idle(2);
        chk("t3_wr_ptr", wr_ptr, 2);
        chk("t3_count", count, 4);
        rdf(0, 5);
        rdf(1, 6);
        rdf(2, 3);
        rdf(3, 4);

        // read of the slot being committed returns old data
        for (int c = 0; c < 4; c++) send_word(fw(7, c));
        s_if.s_valid_i = 1'b0;
        model_commit();
        rdf(2, 3);
        idle(2);
        rdf(2, 7);
        chk("t3b_count", count, 4);

        // clear with valid high and a read judged on pre-clear count
        clear          = 1'b1;
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = 32'hDEAD;
        rd_en          = 1'b1;
        rd_idx         = IW'(1);
        rq.push_back('{1'b0, fw(6, 0), fw(6, 1), fw(6, 2), fw(6, 3)});
        @(negedge clk);
        chk("t5_ready_clear", s_if.s_ready_o, 0);
        @(posedge clk);
        #1;
        clear          = 1'b0;
        rd_en          = 1'b0;
        s_if.s_valid_i = 1'b0;
        exp_ptr        = '0;
        exp_cnt        = '0;

        // 5: clear mid-frame discards staged words
        send_word(fw(8, 0));
        send_word(fw(8, 1));
        s_if.s_valid_i = 1'b0;
        clear_pulse();
        send_frame(9);
        idle(2);
        chk("t5_count", count, 1);
        chk("t5_wr_ptr", wr_ptr, 1);
        rdf(0, 9);

        // 4: out-of-range read
        send_frame(10);
        idle(2);
        chk("t4_count", count, 2);
        rd(2, 1'b1, 0, 0, 0, 0);
        rdf(1, 10);
        rdf(0, 9);

        // 6: reset during a commit cycle
        for (int c = 0; c < 4; c++) send_word(fw(11, c));
        s_if.s_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset();
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        exp_ptr = '0;
        exp_cnt = '0;
        @(posedge clk);
        #1;
        idle(2);
        chk("t6_count", count, 0);
        chk("t6_wr_ptr", wr_ptr, 0);
        send_frame(12);
        idle(2);
        chk("t6_count2", count, 1);
        rdf(0, 12);

        idle(3);
        chk("rdq_empty", rq.size(), 0);
        chk("fdq_empty", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
